// File: rtl/alu_mdu_if.sv
// Operand/result bundle between the EX-stage controller (master) and alu_mdu (slave).
// Port names follow the original datapath ALU so existing controllers map across directly.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [4:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] C;
  logic             Zero;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             divz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ALUOp, A, B, shamt,
    input  C, Zero, busy, done, ovf, divz, hi, lo
  );

  modport slave (
    input  start, ALUOp, A, B, shamt,
    output C, Zero, busy, done, ovf, divz, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with an optional iterative multiply/divide unit writing HI/LO.
// Define ALU_MDU_EN to build the multiply/divide unit; without it opcodes 13-18 return 0.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rstn,
  alu_mdu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADDU = 5'd0;
  localparam logic [4:0] OP_SUBU = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NOR  = 5'd11;
  localparam logic [4:0] OP_SLTU = 5'd12;
`ifdef ALU_MDU_EN
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
`endif

  logic [WIDTH-1:0] c_q;
  logic             done_q;
  logic             ovf_q;
  logic             accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
`ifdef ALU_MDU_EN
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
`endif

  assign sh       = bus.shamt;
  assign add_res  = bus.A + bus.B;
  assign sub_res  = bus.A - bus.B;
  assign bus.Zero = (bus.A == bus.B);
  assign bus.C    = c_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUOp)
      OP_ADDU: alu_res = add_res;
      OP_SUBU: alu_res = sub_res;
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_res[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_OR:   alu_res = bus.A | bus.B;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL:  alu_res = bus.B << sh;
      OP_SRL:  alu_res = bus.B >> sh;
      OP_SRA:  alu_res = $signed(bus.B) >>> sh;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_NOR:  alu_res = ~(bus.A | bus.B);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
`ifdef ALU_MDU_EN
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MDU_EN
  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNTW-1:0]  cnt;
  logic             busy_q;
  logic             divz_q;
  logic             is_mdu;
  logic             op_signed;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lreg;
  logic [WIDTH-1:0] mreg;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign bus.busy = busy_q;
  assign bus.divz = divz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  assign is_mdu    = (bus.ALUOp == OP_MULT) || (bus.ALUOp == OP_MULTU) ||
                     (bus.ALUOp == OP_DIV)  || (bus.ALUOp == OP_DIVU);
  // busy lags the state by one cycle, so the FSM itself also gates acceptance.
  assign accept    = bus.start && !busy_q && (state == IDLE);
  assign op_signed = (bus.ALUOp == OP_MULT) || (bus.ALUOp == OP_DIV);
  assign sa        = op_signed && bus.A[WIDTH-1];
  assign sb        = op_signed && bus.B[WIDTH-1];
  assign amag      = sa ? -bus.A : bus.A;
  assign bmag      = sb ? -bus.B : bus.B;

  assign mul_sum   = {1'b0, acc} + (lreg[0] ? {1'b0, mreg} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc, lreg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mreg});
  assign div_diff  = div_shift[WIDTH-1:0] - mreg;

  assign prod      = {acc, lreg};
  assign prod_fix  = neg_q ? -prod : prod;
  // A zero divisor leaves the dividend magnitude in acc, so rem_fix already equals A.
  assign quo_fix   = dz ? '1 : (neg_q ? -lreg : lreg);
  assign rem_fix   = neg_r ? -acc : acc;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mdu) state_nxt = ITER;
      ITER:    if (cnt == CNTW'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      c_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      divz_q <= 1'b0;
      busy_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      lreg   <= '0;
      mreg   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      divz_q <= 1'b0;
      busy_q <= (state != IDLE);
      case (state)
        IDLE: begin
          if (accept && is_mdu) begin
            acc    <= '0;
            lreg   <= amag;
            mreg   <= bmag;
            is_div <= (bus.ALUOp == OP_DIV) || (bus.ALUOp == OP_DIVU);
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= (bus.B == '0);
            cnt    <= CNTW'(WIDTH);
          end else if (accept) begin
            done_q <= 1'b1;
            ovf_q  <= alu_ovf;
            if (!alu_ovf) c_q <= alu_res;
          end
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            lreg <= {lreg[WIDTH-2:0], div_ge};
          end else begin
            acc  <= mul_sum[WIDTH:1];
            lreg <= {mul_sum[0], lreg[WIDTH-1:1]};
          end
        end
        FIN: begin
          done_q <= 1'b1;
          if (is_div) begin
            hi_q   <= rem_fix;
            lo_q   <= quo_fix;
            divz_q <= dz;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign accept   = bus.start;
  assign bus.busy = 1'b0;
  assign bus.divz = 1'b0;
  assign bus.hi   = '0;
  assign bus.lo   = '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      c_q    <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      if (accept) begin
        done_q <= 1'b1;
        ovf_q  <= alu_ovf;
        if (!alu_ovf) c_q <= alu_res;
      end
    end
  end
`endif
endmodule
